// File: rtl/io_delay_chain_if.sv
`default_nettype none
// ============================================================================
// Module      : io_delay_chain_if
// Description : Control, data and status bundle for io_delay_chain.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_delay_chain_if #(
    parameter int WIDTH       = 2,
    parameter int COUNT_WIDTH = 8
);
    logic                   i_Enable;
    logic                   i_Clear;
    logic [WIDTH-1:0]       i_Data;
    logic [WIDTH-1:0]       o_Data;
    logic [WIDTH-1:0]       o_Comb;
    logic                   o_AllHigh;
    logic                   o_Valid;
    logic [COUNT_WIDTH-1:0] o_ChangeCount;
    logic                   o_Saturated;

    modport master (
        output i_Enable, i_Clear, i_Data,
        input  o_Data, o_Comb, o_AllHigh, o_Valid, o_ChangeCount, o_Saturated
    );

    modport slave (
        input  i_Enable, i_Clear, i_Data,
        output o_Data, o_Comb, o_AllHigh, o_Valid, o_ChangeCount, o_Saturated
    );
endinterface
`default_nettype wire

// File: rtl/io_delay_chain.sv
`default_nettype none
// ============================================================================
// Module      : io_delay_chain
// Description : WIDTH-channel enable-gated delay pipeline with per-channel
//               inversion, bypass, fill-valid flag and saturating change count.
// Revision    : 1.0 - initial release
// ============================================================================
module io_delay_chain #(
    parameter int               WIDTH       = 2,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] INVERT_MASK = '0,
    parameter int               COUNT_WIDTH = 8
) (
    input  wire logic        i_Clock,
    input  wire logic        i_Reset_n,
    io_delay_chain_if.slave  bus
);

    localparam int                     c_FILL_W    = $clog2(DEPTH + 1);
    localparam logic [c_FILL_W-1:0]    c_FILL_FULL = c_FILL_W'(DEPTH);
    localparam logic [c_FILL_W-1:0]    c_FILL_LAST = c_FILL_W'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_PRE = c_COUNT_MAX - COUNT_WIDTH'(1);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [c_FILL_W-1:0]         r_fill;
    logic                        r_valid;
    logic [COUNT_WIDTH-1:0]      r_count;
    logic                        r_sat;

    logic [WIDTH-1:0]            w_entry;
    logic [WIDTH-1:0]            w_tail_next;
    logic                        w_change;

    assign w_entry = bus.i_Data ^ INVERT_MASK;

    // Value the last stage will take on an enabled edge; with one stage it is the entry itself.
    generate
        if (DEPTH == 1) begin : g_tail_direct
            assign w_tail_next = w_entry;
        end else begin : g_tail_shift
            assign w_tail_next = r_stage[DEPTH-2];
        end
    endgenerate

    assign w_change = bus.i_Enable && (w_tail_next != r_stage[DEPTH-1]);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_stage <= '0;
        end else if (bus.i_Enable) begin
            r_stage[0] <= w_entry;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else if (bus.i_Enable && (r_fill != c_FILL_FULL)) begin
            r_fill <= r_fill + c_FILL_W'(1);
            if (r_fill == c_FILL_LAST) begin
                r_valid <= 1'b1;
            end
        end
    end

    // Clear wins over a coincident change event, which is then dropped.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (bus.i_Clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_change && (r_count != c_COUNT_MAX)) begin
            r_count <= r_count + COUNT_WIDTH'(1);
            if (r_count == c_COUNT_PRE) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign bus.o_Data        = r_stage[DEPTH-1];
    assign bus.o_Comb        = w_entry;
    assign bus.o_AllHigh     = &r_stage[DEPTH-1];
    assign bus.o_Valid       = r_valid;
    assign bus.o_ChangeCount = r_count;
    assign bus.o_Saturated   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_io_delay_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_delay_chain
// Description : Randomised bench for io_delay_chain against a sample-history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_delay_chain;

    localparam int          c_DEPTH_A = 3;
    localparam logic [1:0]  c_MASK_A  = 2'b10;
    localparam int          c_CMAX_A  = 15;
    localparam int          c_DEPTH_B = 1;
    localparam logic [1:0]  c_MASK_B  = 2'b00;
    localparam int          c_CMAX_B  = 3;

    logic clk;
    logic rst_n;

    io_delay_chain_if #(.WIDTH(2), .COUNT_WIDTH(4)) ifa ();
    io_delay_chain_if #(.WIDTH(2), .COUNT_WIDTH(2)) ifb ();

    io_delay_chain #(.WIDTH(2), .DEPTH(c_DEPTH_A), .INVERT_MASK(c_MASK_A), .COUNT_WIDTH(4)) u_dut_a (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (ifa.slave)
    );

    io_delay_chain #(.WIDTH(2), .DEPTH(c_DEPTH_B), .INVERT_MASK(c_MASK_B), .COUNT_WIDTH(2)) u_dut_b (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference: full history of entry samples since reset; output is the sample DEPTH enables back.
    logic [1:0] hist_a [0:4095];
    logic [1:0] hist_b [0:4095];
    int         nh_a, nh_b;
    int         cnt_a, cnt_b;

    function automatic logic [1:0] exp_out_a();
        return (nh_a >= c_DEPTH_A) ? hist_a[nh_a - c_DEPTH_A] : 2'b00;
    endfunction

    function automatic logic [1:0] exp_out_b();
        return (nh_b >= c_DEPTH_B) ? hist_b[nh_b - c_DEPTH_B] : 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        nh_a = 0; nh_b = 0; cnt_a = 0; cnt_b = 0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [1:0] d);
        logic [1:0] old_a, old_b;
        old_a = exp_out_a();
        old_b = exp_out_b();
        if (en) begin
            hist_a[nh_a] = d ^ c_MASK_A; nh_a++;
            hist_b[nh_b] = d ^ c_MASK_B; nh_b++;
        end
        if (clr) begin
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (exp_out_a() != old_a && cnt_a < c_CMAX_A) cnt_a++;
            if (exp_out_b() != old_b && cnt_b < c_CMAX_B) cnt_b++;
        end
    endtask

    task automatic check_all();
        logic [1:0] ea, eb;
        ea = exp_out_a();
        eb = exp_out_b();
        check("a_data",  32'(ifa.o_Data), 32'(ea));
        check("a_all",   32'(ifa.o_AllHigh), 32'(&ea));
        check("a_valid", 32'(ifa.o_Valid), 32'(nh_a >= c_DEPTH_A));
        check("a_count", 32'(ifa.o_ChangeCount), 32'(cnt_a));
        check("a_sat",   32'(ifa.o_Saturated), 32'(cnt_a == c_CMAX_A));
        check("b_data",  32'(ifb.o_Data), 32'(eb));
        check("b_all",   32'(ifb.o_AllHigh), 32'(&eb));
        check("b_valid", 32'(ifb.o_Valid), 32'(nh_b >= c_DEPTH_B));
        check("b_count", 32'(ifb.o_ChangeCount), 32'(cnt_b));
        check("b_sat",   32'(ifb.o_Saturated), 32'(cnt_b == c_CMAX_B));
    endtask

    task automatic drive(input logic en, input logic clr, input logic [1:0] d);
        ifa.i_Enable = en; ifa.i_Clear = clr; ifa.i_Data = d;
        ifb.i_Enable = en; ifb.i_Clear = clr; ifb.i_Data = d;
    endtask

    // Inputs are applied just after an edge, the bypass is checked, then one edge is taken.
    task automatic step(input logic en, input logic clr, input logic [1:0] d);
        drive(en, clr, d);
        #1;
        check("a_comb", 32'(ifa.o_Comb), 32'(d ^ c_MASK_A));
        check("b_comb", 32'(ifb.o_Comb), 32'(d ^ c_MASK_B));
        @(posedge clk);
        model_edge(en, clr, d);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] d;
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        check("rst_comb_a", 32'(ifa.o_Comb), 32'(2'b01));
        check("rst_comb_b", 32'(ifb.o_Comb), 32'(2'b11));
        check_all();
        #3;
        rst_n = 1'b1;

        // Fill then latency pulse: o_Valid of the 3-stage instance rises on the third edge.
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 2'b00);
        check("valid_pre", 32'(ifa.o_Valid), 32'd0);
        step(1'b1, 1'b0, 2'b00);
        check("valid_3rd", 32'(ifa.o_Valid), 32'd1);
        check("lat_pulse", 32'(ifa.o_Data), 32'(2'b11));
        step(1'b1, 1'b0, 2'b00);
        check("lat_after", 32'(ifa.o_Data), 32'(2'b10));
        repeat (2) step(1'b1, 1'b0, 2'b00);

        // Same pulse with a four-cycle enable gap after the first sample.
        step(1'b1, 1'b0, 2'b01);
        repeat (4) step(1'b0, 1'b0, 2'b11);
        repeat (4) step(1'b1, 1'b0, 2'b00);

        // Toggle channel 0 until the 2-bit counter saturates, then clear alongside a toggle.
        d = 2'b00;
        for (int i = 0; i < 6; i++) begin
            d[0] = ~d[0];
            step(1'b1, 1'b0, d);
        end
        check("b_sat_hold", 32'(ifb.o_Saturated), 32'd1);
        d[0] = ~d[0];
        step(1'b1, 1'b1, d);
        check("b_clr_cnt", 32'(ifb.o_ChangeCount), 32'd0);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            step(($urandom % 4) != 0, ($urandom % 16) == 0, 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_delay_chain.md
Name: io_delay_chain

Overview:
- Parametrised successor to the single-bit registered/inverted I/O test design.
- Carries WIDTH input channels through a DEPTH-stage enable-gated shift pipeline, with a compile-time per-channel inversion mask.
- Provides a combinational bypass path, a fill-valid flag and a saturating output-change counter.
- Used as a fabric bring-up design that exercises flip-flops, LUT inversion, clock enables, async reset and carry logic in one block.

Parameters:
- WIDTH, 2, number of data channels (>=1)
- DEPTH, 3, number of pipeline register stages (>=1)
- INVERT_MASK, 0 (WIDTH bits), bit i=1 inverts channel i at pipeline entry and on the bypass path
- COUNT_WIDTH, 8, width of the change counter (>=2)

Ports:
- i_Clock  input  1  sole clock; all state updates on rising edge
- i_Reset_n  input  1  asynchronous, active-low reset
- i_Enable  input  1  pipeline advance enable
- i_Clear  input  1  synchronous clear of the change counter and saturation flag
- i_Data  input  WIDTH  channel inputs
- o_Data  output  WIDTH  registered output of pipeline stage DEPTH-1
- o_Comb  output  WIDTH  combinational i_Data ^ INVERT_MASK
- o_AllHigh  output  1  combinational &o_Data
- o_Valid  output  1  registered; pipeline filled since reset
- o_ChangeCount  output  COUNT_WIDTH  registered count of o_Data updates that changed value
- o_Saturated  output  1  registered; o_ChangeCount has reached its maximum

Behaviour:
- Reset (i_Reset_n=0, asynchronous):
  - all pipeline stages = 0, so o_Data = 0
  - o_Valid = 0, o_ChangeCount = 0, o_Saturated = 0
  - o_Comb and o_AllHigh follow their equations (o_AllHigh = 0 while o_Data = 0 and WIDTH>=1)
- Reset assertion mid-operation clears all state immediately; release takes effect at the first rising edge after deassertion.
- Pipeline:
  - On a rising edge with i_Enable=1: stage0 <= i_Data ^ INVERT_MASK and stage k <= stage k-1 for k=1..DEPTH-1.
  - With i_Enable=0 all stages hold.
  - Latency is exactly DEPTH enabled edges: a value sampled at enabled edge n appears on o_Data after enabled edge n+DEPTH-1. With DEPTH=1, o_Data updates on the same edge that samples i_Data.
  - Enable gaps stretch latency in cycles but never drop or duplicate samples.
- Fill tracking:
  - Internal fill counter, ceil(log2(DEPTH+1)) bits, increments on each enabled edge and saturates at DEPTH.
  - o_Valid = 1 on the edge where the counter reaches DEPTH, and holds until reset.
  - i_Enable=0 does not clear o_Valid.
- Change counter:
  - Event = enabled edge where the new stage DEPTH-1 value != current o_Data.
  - On an event, o_ChangeCount increments by 1, saturating at 2^COUNT_WIDTH-1. o_Saturated is set on the edge the count reaches the maximum and stays set.
  - Further events at saturation leave both outputs unchanged.
  - i_Clear=1 at an edge: o_ChangeCount <= 0 and o_Saturated <= 0, taking priority over a simultaneous event; that event is not counted.
  - i_Clear does not affect the pipeline or o_Valid.
- Combinational outputs have no registers. o_Comb responds to i_Data in the same cycle regardless of i_Enable and reset.
- Widths: INVERT_MASK is zero-extended or truncated to WIDTH. Counters use unsigned arithmetic only.

Test Plan:
- Reset/fill (WIDTH=2, DEPTH=3, mask=2'b10):
  - hold i_Reset_n=0 with i_Data=2'b11 -> o_Data=0, o_Valid=0, o_ChangeCount=0, o_Comb=2'b01
  - release, i_Enable=1 -> o_Valid rises on the 3rd edge
- Latency: i_Enable=1, drive i_Data=2'b01 for one edge, then 2'b00 -> o_Data=2'b11 appears after the 3rd enabled edge, one cycle wide, followed by 2'b10; o_ChangeCount=2.
- Enable gating: same stimulus with i_Enable low for 4 cycles between the 1st and 2nd edges -> o_Data sequence is identical, delayed by 4 cycles; no extra change counts.
- Saturation/clear (COUNT_WIDTH=2, DEPTH=1, mask=0):
  - toggle i_Data[0] every cycle -> count 1,2,3, then holds at 3; o_Saturated=1 at count 3
  - assert i_Clear concurrent with a toggle -> count=0, o_Saturated=0 next edge
- Async reset mid-operation: assert i_Reset_n=0 between clock edges with the pipeline full and count=5 -> o_Data, o_Valid, o_ChangeCount go to 0 before the next edge; after release the pipeline refills in 3 enabled edges.
- o_AllHigh: mask=0, i_Data=2'b11 held -> o_AllHigh=1 once o_Data=2'b11. Then i_Data=2'b10 -> o_AllHigh falls exactly 3 enabled edges later.
